// File: rtl/irq_sequencer_pkg.sv
// Shared constants for the interrupt sequencer: control-transfer opcodes,
// the handler vector address and the dispatch FSM encoding.
package irq_sequencer_pkg;

    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_RET = 6'b010000;
    localparam logic [5:0] OP_JV  = 6'b011100;
    localparam logic [5:0] OP_JNV = 6'b011101;
    localparam logic [5:0] OP_JZ  = 6'b011110;
    localparam logic [5:0] OP_JNZ = 6'b011111;

    localparam logic [15:0] IRQ_VECTOR = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRE    = 3'd1,
        ST_VEC1    = 3'd2,
        ST_VEC2    = 3'd3,
        ST_SERVICE = 3'd4
    } irq_state_e;

    // A dispatch alongside one of these would corrupt the saved return address.
    function automatic logic is_ctrl_xfer(input logic [5:0] op);
        return (op == OP_JMP) || (op == OP_RET) || (op == OP_JV) ||
               (op == OP_JNV) || (op == OP_JZ)  || (op == OP_JNZ);
    endfunction

endpackage

// File: rtl/irq_sequencer_prio.sv
// Fixed-priority encoder: reports the lowest set index of req_i.
module irq_prio_enc #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Edge-latching, maskable interrupt sequencer that pulses the jump unit once
// per dispatch and holds off further dispatch until the handler's RET.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_req,
    input  logic [5:0]       op_dec,
    input  logic             gie,
    input  logic             cfg_we,
    input  logic [N_SRC-1:0] cfg_mask,
    output logic             interrupt,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);

    irq_state_e       state_q;
    logic [N_SRC-1:0] req_q, pending_q, pending_d, mask_q;
    logic [N_SRC-1:0] req_edge, elig, clr;
    logic             interrupt_q, in_service_q, win_valid, dispatch;
    logic [ID_W-1:0]  irq_id_q, winner;

    assign req_edge = irq_req & ~req_q;
    assign elig     = pending_q & mask_q;

    irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
        .req_i   (elig),
        .valid_o (win_valid),
        .idx_o   (winner)
    );

    assign dispatch = (state_q == ST_IDLE) && win_valid && gie && !is_ctrl_xfer(op_dec);

    // Set is applied after clear so a coincident new edge keeps the bit pending.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = dispatch && (winner == ID_W'(i));
        end
        pending_d = (pending_q & ~clr) | req_edge;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            req_q     <= irq_req;
            pending_q <= pending_d;
            if (cfg_we) mask_q <= cfg_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            interrupt_q  <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            interrupt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dispatch) begin
                        interrupt_q  <= 1'b1;
                        irq_id_q     <= winner;
                        in_service_q <= 1'b1;
                        state_q      <= ST_FIRE;
                    end
                end
                ST_FIRE: state_q <= ST_VEC1;
                ST_VEC1: state_q <= ST_VEC2;
                ST_VEC2: state_q <= ST_SERVICE;
                ST_SERVICE: begin
                    if (op_dec == OP_RET) begin
                        in_service_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign interrupt  = interrupt_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed self-checking bench for irq_sequencer with hand-computed expectations.
module tb_irq_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_req;
    logic [5:0] op_dec;
    logic       gie;
    logic       cfg_we;
    logic [3:0] cfg_mask;
    logic       interrupt;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] mask;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] RET = 6'b010000;

    irq_sequencer #(.N_SRC(4), .ID_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_req    (irq_req),
        .op_dec     (op_dec),
        .gie        (gie),
        .cfg_we     (cfg_we),
        .cfg_mask   (cfg_mask),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the FIRE state: run through the vector cycles into SERVICE and retire with RET.
    task automatic run_to_ret();
        tick(); tick(); tick();
        op_dec = RET;
        tick();
        op_dec = NOP;
    endtask

    task automatic test_reset();
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL rst_int got=%0b exp=0", interrupt); end
        total++; if (irq_id !== 2'd0)     begin bad++; $display("[TB] FAIL rst_id got=%0d exp=0", irq_id); end
        total++; if (in_service !== 1'b0) begin bad++; $display("[TB] FAIL rst_insvc got=%0b exp=0", in_service); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL rst_pend got=%b exp=0000", pending); end
        total++; if (mask !== 4'b0000)    begin bad++; $display("[TB] FAIL rst_mask got=%b exp=0000", mask); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        gie = 1'b1; cfg_we = 1'b1; cfg_mask = 4'b1111;
        tick();
        cfg_we = 1'b0;
        total++; if (mask !== 4'b1111) begin bad++; $display("[TB] FAIL basic_mask got=%b exp=1111", mask); end
        irq_req = 4'b0100;
        tick();
        total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL basic_pend got=%b exp=0100", pending); end
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL basic_early got=%0b exp=0", interrupt); end
        tick();
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL basic_int got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd2)     begin bad++; $display("[TB] FAIL basic_id got=%0d exp=2", irq_id); end
        total++; if (in_service !== 1'b1) begin bad++; $display("[TB] FAIL basic_insvc got=%0b exp=1", in_service); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL basic_clr got=%b exp=0000", pending); end
        irq_req = 4'b0000;
        tick();
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL basic_onecyc got=%0b exp=0", interrupt); end
        tick(); tick();
        total++; if (in_service !== 1'b1) begin bad++; $display("[TB] FAIL basic_svc got=%0b exp=1", in_service); end
        op_dec = RET;
        tick();
        op_dec = NOP;
        total++; if (in_service !== 1'b0) begin bad++; $display("[TB] FAIL basic_ret got=%0b exp=0", in_service); end
    endtask

    task automatic test_priority();
        irq_req = 4'b1010;
        tick();
        total++; if (pending !== 4'b1010) begin bad++; $display("[TB] FAIL prio_pend got=%b exp=1010", pending); end
        tick();
        irq_req = 4'b0000;
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL prio_int1 got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd1)     begin bad++; $display("[TB] FAIL prio_id1 got=%0d exp=1", irq_id); end
        total++; if (pending !== 4'b1000) begin bad++; $display("[TB] FAIL prio_left got=%b exp=1000", pending); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL prio_nest got=%0b exp=0 cyc=%0d", interrupt, i); end
        end
        op_dec = RET;
        tick();
        op_dec = NOP;
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL prio_retcyc got=%0b exp=0", interrupt); end
        total++; if (in_service !== 1'b0) begin bad++; $display("[TB] FAIL prio_ret got=%0b exp=0", in_service); end
        tick();
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL prio_int2 got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd3)     begin bad++; $display("[TB] FAIL prio_id2 got=%0d exp=3", irq_id); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL prio_clr got=%b exp=0000", pending); end
        run_to_ret();
    endtask

    task automatic test_masking();
        cfg_we = 1'b1; cfg_mask = 4'b1110;
        tick();
        cfg_we = 1'b0;
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0000;
        total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL mask_pend got=%b exp=0001", pending); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL mask_block got=%0b exp=0 cyc=%0d", interrupt, i); end
        end
        cfg_we = 1'b1; cfg_mask = 4'b1111;
        tick();
        cfg_we = 1'b0;
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL mask_wrcyc got=%0b exp=0", interrupt); end
        total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL mask_keep got=%b exp=0001", pending); end
        tick();
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL mask_int got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd0)     begin bad++; $display("[TB] FAIL mask_id got=%0d exp=0", irq_id); end
        run_to_ret();
    endtask

    task automatic test_jump_block();
        logic [5:0] ops [6];
        ops[0] = 6'b011000; ops[1] = 6'b011000; ops[2] = 6'b011000;
        ops[3] = 6'b011100; ops[4] = 6'b011110; ops[5] = 6'b011111;
        op_dec = 6'b011000;
        irq_req = 4'b0010;
        tick();
        irq_req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            op_dec = ops[i];
            tick();
            total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL jmp_block got=%0b exp=0 op=%b", interrupt, ops[i]); end
        end
        op_dec = 6'b011101;
        tick();
        total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL jnv_block got=%0b exp=0", interrupt); end
        op_dec = RET;
        tick();
        total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL ret_block got=%0b exp=0", interrupt); end
        op_dec = NOP;
        tick();
        total++; if (interrupt !== 1'b1) begin bad++; $display("[TB] FAIL jmp_release got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd1)    begin bad++; $display("[TB] FAIL jmp_id got=%0d exp=1", irq_id); end
        run_to_ret();
    endtask

    task automatic test_gie_setwins_nest();
        gie = 1'b0;
        irq_req = 4'b0100;
        tick();
        irq_req = 4'b0000;
        tick(); tick();
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL gie_block got=%0b exp=0", interrupt); end
        total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL gie_pend got=%b exp=0100", pending); end
        gie = 1'b1;
        irq_req = 4'b0100;
        tick();
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL sw_int got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd2)     begin bad++; $display("[TB] FAIL sw_id got=%0d exp=2", irq_id); end
        total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL sw_setwins got=%b exp=0100", pending); end
        tick();
        total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL sw_held got=%b exp=0100", pending); end
        irq_req = 4'b0101;
        tick();
        total++; if (pending !== 4'b0101) begin bad++; $display("[TB] FAIL nest_pend got=%b exp=0101", pending); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL nest_block got=%0b exp=0 cyc=%0d", interrupt, i); end
        end
        total++; if (irq_id !== 2'd2)     begin bad++; $display("[TB] FAIL nest_id got=%0d exp=2", irq_id); end
        op_dec = RET;
        tick();
        op_dec = NOP;
        irq_req = 4'b0000;
        tick();
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL nest_int got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd0)     begin bad++; $display("[TB] FAIL nest_id0 got=%0d exp=0", irq_id); end
        total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL nest_left got=%b exp=0100", pending); end
        run_to_ret();
        tick();
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL sw_int2 got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd2)     begin bad++; $display("[TB] FAIL sw_id2 got=%0d exp=2", irq_id); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL sw_clr got=%b exp=0000", pending); end
        run_to_ret();
    endtask

    task automatic test_reset_mid();
        irq_req = 4'b1000;
        tick();
        irq_req = 4'b0010;
        tick();
        irq_req = 4'b0000;
        total++; if (irq_id !== 2'd3)     begin bad++; $display("[TB] FAIL mid_id got=%0d exp=3", irq_id); end
        tick();
        total++; if (pending !== 4'b0010) begin bad++; $display("[TB] FAIL mid_pend got=%b exp=0010", pending); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (interrupt !== 1'b0)  begin bad++; $display("[TB] FAIL arst_int got=%0b exp=0", interrupt); end
        total++; if (irq_id !== 2'd0)     begin bad++; $display("[TB] FAIL arst_id got=%0d exp=0", irq_id); end
        total++; if (in_service !== 1'b0) begin bad++; $display("[TB] FAIL arst_insvc got=%0b exp=0", in_service); end
        total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL arst_pend got=%b exp=0000", pending); end
        total++; if (mask !== 4'b0000)    begin bad++; $display("[TB] FAIL arst_mask got=%b exp=0000", mask); end
        tick();
        reset = 1'b1;
        cfg_we = 1'b1; cfg_mask = 4'b1111;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (interrupt !== 1'b0) begin bad++; $display("[TB] FAIL post_rst got=%0b exp=0 cyc=%0d", interrupt, i); end
        end
        irq_req = 4'b0100;
        tick();
        tick();
        irq_req = 4'b0000;
        total++; if (interrupt !== 1'b1)  begin bad++; $display("[TB] FAIL post_int got=%0b exp=1", interrupt); end
        total++; if (irq_id !== 2'd2)     begin bad++; $display("[TB] FAIL post_id got=%0d exp=2", irq_id); end
        run_to_ret();
    endtask

    initial begin
        reset = 1'b0; irq_req = '0; op_dec = NOP; gie = 1'b0; cfg_we = 1'b0; cfg_mask = '0;
        tick(); tick();
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_jump_block();
        test_gie_setwins_nest();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Multi-source interrupt controller in front of the jump/PC-select logic.
- Latches edge-triggered requests from up to N_SRC peripherals and masks them.
- Picks the highest-priority pending source and drives a single-cycle `interrupt` pulse into the jump control unit, which vectors to 0xF000 and saves the return address and flags.
- Blocks further interrupts until the handler's RET is decoded, because the jump unit holds only one return context.

Parameters:
- N_SRC, 4, number of interrupt sources (2..8).
- ID_W, 2, width of the source id; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- irq_req  in  N_SRC  peripheral request lines, synchronous to clk, rising-edge sensitive.
- op_dec  in  6  decoded opcode of the instruction currently in decode stage.
- gie  in  1  global interrupt enable; 0 blocks new dispatch.
- cfg_we  in  1  mask write strobe.
- cfg_mask  in  N_SRC  new mask value; bit=1 enables the source.
- interrupt  out  1  one-cycle pulse to the jump control unit.
- irq_id  out  ID_W  id of the source in service; held until the next dispatch.
- in_service  out  1  high from dispatch until RET is accepted.
- pending  out  N_SRC  latched pending requests (read-back).
- mask  out  N_SRC  current mask register.

Behaviour:
- Reset (reset=0, asynchronous):
  - interrupt=0, irq_id=0, in_service=0, pending=0, mask=0.
  - Edge-detect history = 0; FSM = IDLE.
  - Reset mid-sequence abandons the sequence with no pulse and no pending retained.
- Edge detect:
  - edge[i] = irq_req[i] & ~req_q[i]; req_q is irq_req registered each cycle.
  - A held-high line produces only one edge.
- Pending:
  - A bit sets on edge[i] and clears when its source is dispatched.
  - If an edge and a dispatch-clear of the same bit coincide, set wins and the bit stays pending.
  - Masked sources still accumulate pending; they are never selected.
- Mask:
  - Written when cfg_we=1; the new value applies from the next cycle.
  - Writing the mask never clears pending.
- Eligibility: elig = pending & mask. Priority is fixed, lowest index highest.
- Dispatch blocking. No dispatch in the cycle when any of these holds:
  - op_dec is a control-transfer opcode: JMP 6'b011000, RET 6'b010000, JV 6'b011100, JNV 6'b011101, JZ 6'b011110, JNZ 6'b011111. This keeps the saved return address (current+1) correct.
  - gie=0.
- FSM:
  - IDLE: if elig!=0, no blocking condition and gie=1 → FIRE. At this edge:
    - interrupt<=1
    - irq_id<=winner
    - pending[winner] cleared
    - in_service<=1
  - FIRE (1 cycle): interrupt<=0; → VEC1.
  - VEC1 (1 cycle): → VEC2. This matches the jump unit's forced-jump cycle.
  - VEC2 (1 cycle): → SERVICE. This matches the jump unit's flag-capture cycle.
  - SERVICE:
    - If op_dec==RET → IDLE at the next edge, with in_service<=0.
    - A new dispatch is possible from IDLE, one cycle after leaving SERVICE. The earliest dispatch is thus 2 cycles after RET is decoded.
  - RET decoded in FIRE/VEC1/VEC2 is ignored; it is the pre-vector instruction.
- Latency:
  - Request rising edge at sample edge n → pending set at edge n+1.
  - interrupt high after edge n+2, for exactly one cycle, provided nothing blocks.
- interrupt is never high in two consecutive cycles. No second pulse occurs while in_service=1.
- Edges arriving during service accumulate in pending and are dispatched by priority after RET.

Decomposition:
- Shared package holds:
  - opcode constants OP_JMP, OP_RET, OP_JV, OP_JNV, OP_JZ, OP_JNZ;
  - the vector address constant 16'hF000;
  - FSM state encoding (IDLE, FIRE, VEC1, VEC2, SERVICE; 3 bits).
- One sub-module, irq_prio_enc: combinational, N_SRC-in → valid + ID_W-bit index, lowest index wins.

Test Plan:
- Basic dispatch:
  - Stimulus: reset released, mask=4'b1111, gie=1, irq_req[2] rises.
  - Response: pending=4'b0100 one cycle later; interrupt pulses one cycle after that; irq_id=2, in_service=1, pending=0.
- Priority:
  - Stimulus: irq_req[3] and irq_req[1] rise in the same cycle.
  - Response: first dispatch has irq_id=1 and pending=4'b1000.
  - Then op_dec=6'b010000 during SERVICE → second pulse with irq_id=3, 2 cycles after RET.
- Masking:
  - Stimulus: mask=4'b1110, irq_req[0] rises.
  - Response: pending=4'b0001 and no interrupt.
  - Then write mask=4'b1111 → interrupt with irq_id=0.
- Jump blocking:
  - Stimulus: pending eligible while op_dec=6'b011000 for 3 cycles.
  - Response: interrupt stays 0 throughout; pulses in the first cycle after op_dec changes to a non-jump opcode.
- Nesting block and set-wins:
  - Stimulus: in SERVICE for id 2, irq_req[0] rises; separately, an edge on the source being dispatched in the FIRE edge.
  - Response: no pulse until RET. The coincident bit remains pending=1.
- Async reset mid-sequence:
  - Stimulus: reset=0 asserted during VEC1.
  - Response: all outputs 0 immediately, with no clock edge needed; after release, no pulse until a new edge.
